// File: rtl/branch_pkg.sv
// Shared types and constants for the B/BL branch unit.
// Holds the FSM state enum, register indices and PC increments.
package branch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RDPC,
    LATCH,
    WRLR,
    WRPC
  } state_t;

  localparam logic [3:0]  REG_LR = 4'd14;
  localparam logic [3:0]  REG_PC = 4'd15;

  localparam logic [31:0] PC_INC      = 32'd4;
  localparam logic [31:0] PC_PREFETCH = 32'd8;

  localparam logic [31:0] CPSR_RESET_DFLT = 32'h0000_00D3;

endpackage

// File: rtl/arm_regfile.sv
// 16x32 ARM register file plus CPSR, one write port, registered read.
// Ports: clk, rst_n, wr_en/wr_reg/wr_val, rd_en/rd_reg, rd_value, cpsr_value.
module arm_regfile
  import branch_pkg::*;
#(
  parameter logic [31:0] CPSR_RESET = CPSR_RESET_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  wr_reg,
  input  logic [31:0] wr_val,
  input  logic        rd_en,
  input  logic [3:0]  rd_reg,
  output logic [31:0] rd_value,
  output logic [31:0] cpsr_value
);

  logic [31:0] regs [16];
  logic [31:0] cpsr_q;

  // Read samples the pre-edge array, so a same-edge
  // write to the read index returns the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
      rd_value <= '0;
      cpsr_q   <= CPSR_RESET;
    end else begin
      if (wr_en) begin
        regs[wr_reg] <= wr_val;
      end
      if (rd_en) begin
        rd_value <= regs[rd_reg];
      end
    end
  end

  assign cpsr_value = cpsr_q;

endmodule

// File: rtl/branch_unit.sv
// ARM7 B/BL execution: reads r15, writes optional r14 link and new r15.
// Ports: en/cond/link/offset start, busy/done status, host_* regfile port.
module branch_unit
  import branch_pkg::*;
#(
  parameter logic [31:0] CPSR_RESET = CPSR_RESET_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        cond,
  input  logic        link,
  input  logic [23:0] offset,
  output logic        busy,
  output logic        done,
  input  logic        host_sel,
  input  logic        host_wr_en,
  input  logic [3:0]  host_wr_reg,
  input  logic [31:0] host_wr_val,
  input  logic        host_rd_en,
  input  logic [3:0]  host_rd_reg,
  output logic [31:0] rd_value,
  output logic [31:0] cpsr_value
);

  state_t      state_q, state_d;
  logic        en_q;
  logic        cond_q;
  logic        link_q;
  logic [23:0] off_q;
  logic [31:0] pc_q;
  logic        done_q;

  logic        freeze;
  logic        start;
  logic [31:0] off_ext;
  logic [31:0] next_pc;

  logic        fsm_wr_en;
  logic [3:0]  fsm_wr_reg;
  logic [31:0] fsm_wr_val;
  logic        fsm_rd_en;

  logic        rf_wr_en;
  logic [3:0]  rf_wr_reg;
  logic [31:0] rf_wr_val;
  logic        rf_rd_en;
  logic [3:0]  rf_rd_reg;

  // Host takeover mid-operation stalls the FSM in place.
  assign freeze = host_sel && (state_q != IDLE);
  assign start  = (state_q == IDLE) && en && !en_q;

  // Word offset to byte offset; top sign bits shift out.
  assign off_ext = {{6{off_q[23]}}, off_q, 2'b00};
  assign next_pc = cond_q ? (pc_q + PC_PREFETCH + off_ext)
                          : (pc_q + PC_INC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!freeze) begin
      unique case (state_q)
        IDLE:    if (start) state_d = RDPC;
        RDPC:    state_d = LATCH;
        LATCH:   state_d = WRLR;
        WRLR:    state_d = WRPC;
        WRPC:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    fsm_wr_en  = 1'b0;
    fsm_wr_reg = REG_PC;
    fsm_wr_val = next_pc;
    fsm_rd_en  = 1'b0;
    unique case (state_q)
      RDPC: fsm_rd_en = 1'b1;
      WRLR: begin
        fsm_wr_en  = cond_q && link_q;
        fsm_wr_reg = REG_LR;
        fsm_wr_val = pc_q + PC_INC;
      end
      WRPC: fsm_wr_en = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      cond_q <= 1'b0;
      link_q <= 1'b0;
      off_q  <= '0;
      pc_q   <= '0;
      done_q <= 1'b0;
    end else begin
      en_q   <= en;
      done_q <= (state_q == WRPC) && !freeze;
      if (start) begin
        cond_q <= cond;
        link_q <= link;
        off_q  <= offset;
      end
      if ((state_q == LATCH) && !freeze) begin
        pc_q <= rd_value;
      end
    end
  end

  assign rf_wr_en  = host_sel ? host_wr_en  : fsm_wr_en;
  assign rf_wr_reg = host_sel ? host_wr_reg : fsm_wr_reg;
  assign rf_wr_val = host_sel ? host_wr_val : fsm_wr_val;
  assign rf_rd_en  = host_sel ? host_rd_en  : fsm_rd_en;
  assign rf_rd_reg = host_sel ? host_rd_reg : REG_PC;

  arm_regfile #(
    .CPSR_RESET(CPSR_RESET)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (rf_wr_en),
    .wr_reg    (rf_wr_reg),
    .wr_val    (rf_wr_val),
    .rd_en     (rf_rd_en),
    .rd_reg    (rf_rd_reg),
    .rd_value  (rd_value),
    .cpsr_value(cpsr_value)
  );

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: host reads queue expected values,
// a negedge monitor pops and compares; status checks run inline.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        cond;
  logic        link;
  logic [23:0] offset;
  logic        busy;
  logic        done;
  logic        host_sel;
  logic        host_wr_en;
  logic [3:0]  host_wr_reg;
  logic [31:0] host_wr_val;
  logic        host_rd_en;
  logic [3:0]  host_rd_reg;
  logic [31:0] rd_value;
  logic [31:0] cpsr_value;

  int n_run  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic rd_fire_q = 1'b0;

  logic [31:0] q_exp [$];
  string       q_name[$];

  always #5 clk = ~clk;

  branch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cond       (cond),
    .link       (link),
    .offset     (offset),
    .busy       (busy),
    .done       (done),
    .host_sel   (host_sel),
    .host_wr_en (host_wr_en),
    .host_wr_reg(host_wr_reg),
    .host_wr_val(host_wr_val),
    .host_rd_en (host_rd_en),
    .host_rd_reg(host_rd_reg),
    .rd_value   (rd_value),
    .cpsr_value (cpsr_value)
  );

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // A host read strobe seen at a posedge makes rd_value
  // valid by the following negedge.
  always @(posedge clk)
    rd_fire_q <= host_sel && host_rd_en && rst_n;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rd_fire_q) begin
      if (q_exp.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_read: got %h", rd_value);
      end else begin
        logic [31:0] e;
        string nm;
        e  = q_exp.pop_front();
        nm = q_name.pop_front();
        chk(nm, rd_value, e);
      end
    end
  end

  task automatic host_wr(logic [3:0] r, logic [31:0] v);
    host_sel    = 1'b1;
    host_wr_en  = 1'b1;
    host_wr_reg = r;
    host_wr_val = v;
    @(negedge clk);
    host_wr_en = 1'b0;
    host_sel   = 1'b0;
  endtask

  task automatic host_rd(logic [3:0] r, logic [31:0] e,
                         string nm);
    q_exp.push_back(e);
    q_name.push_back(nm);
    host_sel    = 1'b1;
    host_rd_en  = 1'b1;
    host_rd_reg = r;
    @(negedge clk);
    host_rd_en = 1'b0;
    host_sel   = 1'b0;
  endtask

  // Start pulse held for 'hold' cycles; done must appear
  // five negedges after en is raised.
  task automatic op(logic c, logic l, logic [23:0] o,
                    int hold, string nm);
    int k;
    cond   = c;
    link   = l;
    offset = o;
    en     = 1'b1;
    @(negedge clk);
    k = 1;
    chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
    while (k < hold) begin
      @(negedge clk);
      k++;
    end
    en = 1'b0;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_lat"}, k, 32'd5);
    @(negedge clk);
  endtask

  initial begin
    int k;
    rst_n       = 1'b0;
    en          = 1'b0;
    cond        = 1'b0;
    link        = 1'b0;
    offset      = '0;
    host_sel    = 1'b0;
    host_wr_en  = 1'b0;
    host_wr_reg = '0;
    host_wr_val = '0;
    host_rd_en  = 1'b0;
    host_rd_reg = '0;
    repeat (2) @(negedge clk);
    chk("rst_rd", rd_value, 32'h0);
    chk("rst_cpsr", cpsr_value, 32'h0000_00D3);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    host_wr(4'd15, 32'h1000);
    op(1'b0, 1'b0, 24'd0, 1, "t1");
    host_rd(4'd15, 32'h1004, "t1_pc");

    op(1'b1, 1'b0, 24'd3, 1, "t2");
    host_rd(4'd15, 32'h1018, "t2_pc");
    host_rd(4'd14, 32'h0, "t2_lr");

    host_wr(4'd15, 32'h2000);
    op(1'b1, 1'b1, 24'hFF_FFFE, 1, "t3");
    host_rd(4'd14, 32'h2004, "t3_lr");
    host_rd(4'd15, 32'h2000, "t3_pc");

    host_wr(4'd15, 32'h1000);
    done_cnt = 0;
    op(1'b0, 1'b0, 24'd0, 3, "t4");
    repeat (10) @(negedge clk);
    chk("t4_dones", done_cnt, 32'd1);
    host_rd(4'd15, 32'h1004, "t4_pc");

    host_wr(4'd14, 32'hAAAA);
    host_wr(4'd15, 32'hFFFF_FFFC);
    op(1'b0, 1'b1, 24'd0, 1, "t5");
    host_rd(4'd15, 32'h0, "t5_wrap");
    host_rd(4'd14, 32'hAAAA, "t5_lr");

    host_wr(4'd15, 32'h0);
    op(1'b1, 1'b0, 24'h80_0000, 1, "t6");
    host_rd(4'd15, 32'hFE00_0008, "t6_pc");

    host_wr(4'd3, 32'h5);
    q_exp.push_back(32'h5);
    q_name.push_back("rbw_old");
    host_sel    = 1'b1;
    host_wr_en  = 1'b1;
    host_wr_reg = 4'd3;
    host_wr_val = 32'h9;
    host_rd_en  = 1'b1;
    host_rd_reg = 4'd3;
    @(negedge clk);
    host_wr_en = 1'b0;
    host_rd_en = 1'b0;
    host_sel   = 1'b0;
    host_rd(4'd3, 32'h9, "rbw_new");

    host_wr(4'd15, 32'h100);
    cond   = 1'b0;
    link   = 1'b0;
    offset = '0;
    en     = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    host_sel = 1'b1;
    repeat (3) @(negedge clk);
    chk("frz_busy", {31'd0, busy}, 32'd1);
    host_sel = 1'b0;
    k = 5;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("frz_lat", k, 32'd8);
    @(negedge clk);
    host_rd(4'd15, 32'h104, "frz_pc");

    host_wr(4'd15, 32'h3000);
    host_wr(4'd14, 32'h55);
    host_wr(4'd0, 32'h77);
    cond   = 1'b1;
    link   = 1'b1;
    offset = 24'd1;
    en     = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    chk("mrst_dones", done_cnt, 32'd0);
    for (int i = 0; i < 16; i++) begin
      host_rd(i[3:0], 32'h0, $sformatf("mrst_r%0d", i));
    end
    chk("mrst_cpsr", cpsr_value, 32'h0000_00D3);

    repeat (2) @(negedge clk);
    chk("sb_drain", q_exp.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
